// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared opcodes, FSM state type and decoded-control record for
//          the pipe_ctrl two-stage control pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [5:0] ADD  = 6'h00;
  localparam logic [5:0] SUB  = 6'h01;
  localparam logic [5:0] AND  = 6'h02;
  localparam logic [5:0] XOR  = 6'h03;
  localparam logic [5:0] COM  = 6'h04;
  localparam logic [5:0] MUL  = 6'h05;
  localparam logic [5:0] ADDI = 6'h08;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // trap marks an unlisted opcode; only raised when illegal trapping is built in
  typedef struct packed {
    logic wen;
    logic alusrc;
    logic regdst;
    logic is_mul;
    logic trap;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_dec.sv
// ============================================================================
// Module : ctrl_dec
// Brief  : Combinational opcode decoder. Macro ILLEGAL_TRAP_EN selects
//          whether unlisted opcodes trap or decode as R-type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_dec
  import pipe_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int AOPW = 3
) (
  input  logic [OPW-1:0]  opcode,
  output ctrl_t           ctrl,
  output logic [AOPW-1:0] aluop
);

  assign aluop = opcode[AOPW-1:0];

  always_comb begin
    ctrl = '0;
    if (opcode == OPW'(ADDI)) begin
      ctrl.wen    = 1'b1;
      ctrl.alusrc = 1'b1;
    end else if (opcode == OPW'(ADD) || opcode == OPW'(SUB) ||
                 opcode == OPW'(AND) || opcode == OPW'(XOR) ||
                 opcode == OPW'(COM)) begin
      ctrl.wen    = 1'b1;
      ctrl.regdst = 1'b1;
    end else if (opcode == OPW'(MUL)) begin
      ctrl.wen    = 1'b1;
      ctrl.regdst = 1'b1;
      ctrl.is_mul = 1'b1;
    end else begin
`ifdef ILLEGAL_TRAP_EN
      ctrl.trap   = 1'b1;
`else
      ctrl.wen    = 1'b1;
      ctrl.regdst = 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module : pipe_ctrl
// Brief  : Decode -> EX -> WB control pipeline with multi-cycle MUL hold.
//          ILLEGAL_TRAP_EN enables the sticky illegal-opcode flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int AOPW    = 3,
  parameter int MUL_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [OPW-1:0]  in_opcode,
  output logic            in_ready,
  input  logic            stall_in,
  output logic            ex_valid,
  output logic            ex_alusrc,
  output logic            ex_regdst,
  output logic [AOPW-1:0] ex_aluop,
  output logic            wb_valid,
  output logic            wb_wen,
  output logic            busy,
  output logic            illegal
);

  localparam logic [3:0] c_mul_load  = 4'(MUL_CYC - 1);
  localparam logic       c_mul_holds = (MUL_CYC > 1);

  ctrl_t           w_dec;
  logic [AOPW-1:0] w_aluop;
  logic            w_accept;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_ex_valid;
  logic            r_ex_wen;
  logic            r_ex_alusrc;
  logic            r_ex_regdst;
  logic [AOPW-1:0] r_ex_aluop;
  logic            r_wb_valid;
  logic            r_wb_wen;
  logic            r_illegal;

  ctrl_dec #(
    .OPW  (OPW),
    .AOPW (AOPW)
  ) u_ctrl_dec (
    .opcode (in_opcode),
    .ctrl   (w_dec),
    .aluop  (w_aluop)
  );

  assign in_ready = !stall_in && (r_state == RUN);
  assign w_accept = in_valid && in_ready;

  // Stall freezes everything; MUL_WAIT holds EX and feeds bubbles into WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_ex_valid  <= 1'b0;
      r_ex_wen    <= 1'b0;
      r_ex_alusrc <= 1'b0;
      r_ex_regdst <= 1'b0;
      r_ex_aluop  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_wen    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!stall_in) begin
      case (r_state)
        RUN: begin
          r_wb_valid  <= r_ex_valid;
          r_wb_wen    <= r_ex_valid & r_ex_wen;
          r_ex_valid  <= w_accept;
          r_ex_wen    <= w_accept & w_dec.wen;
          r_ex_alusrc <= w_accept & w_dec.alusrc;
          r_ex_regdst <= w_accept & w_dec.regdst;
          r_ex_aluop  <= w_accept ? w_aluop : '0;
          r_illegal   <= r_illegal | (w_accept & w_dec.trap);
          if (w_accept && w_dec.is_mul && c_mul_holds) begin
            r_state <= MUL_WAIT;
            r_cnt   <= c_mul_load;
          end
        end
        MUL_WAIT: begin
          r_wb_valid <= 1'b0;
          r_wb_wen   <= 1'b0;
          r_cnt      <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_alusrc = r_ex_alusrc;
  assign ex_regdst = r_ex_regdst;
  assign ex_aluop  = r_ex_aluop;
  assign wb_valid  = r_wb_valid;
  assign wb_wen    = r_wb_wen & r_wb_valid;
  assign busy      = (r_state == MUL_WAIT);
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Directed self-checking bench for pipe_ctrl (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

`ifdef ILLEGAL_TRAP_EN
  localparam logic c_trap = 1'b1;
`else
  localparam logic c_trap = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_opcode;
  logic       in_ready;
  logic       stall_in;
  logic       ex_valid;
  logic       ex_alusrc;
  logic       ex_regdst;
  logic [2:0] ex_aluop;
  logic       wb_valid;
  logic       wb_wen;
  logic       busy;
  logic       illegal;

  int n_checks;
  int n_pass;

  pipe_ctrl #(
    .OPW     (6),
    .AOPW    (3),
    .MUL_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_opcode (in_opcode),
    .in_ready  (in_ready),
    .stall_in  (stall_in),
    .ex_valid  (ex_valid),
    .ex_alusrc (ex_alusrc),
    .ex_regdst (ex_regdst),
    .ex_aluop  (ex_aluop),
    .wb_valid  (wb_valid),
    .wb_wen    (wb_wen),
    .busy      (busy),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid: got %b want 0", ex_valid); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", wb_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (ex_aluop !== 3'd0) $display("FAIL rst_ex_aluop: got %0d want 0", ex_aluop); else n_pass++;
    n_checks++; if (wb_wen !== 1'b0) $display("FAIL rst_wb_wen: got %b want 0", wb_wen); else n_pass++;
  endtask

  task automatic test_back_to_back();
    in_valid  = 1'b1;
    in_opcode = 6'h00;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", in_ready); else n_pass++;
    tick();
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL b2b_ex_valid1: got %b want 1", ex_valid); else n_pass++;
    n_checks++; if (ex_regdst !== 1'b1) $display("FAIL b2b_ex_regdst1: got %b want 1", ex_regdst); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", in_ready); else n_pass++;
    in_opcode = 6'h08;
    tick();
    n_checks++; if (ex_regdst !== 1'b0) $display("FAIL b2b_ex_regdst2: got %b want 0", ex_regdst); else n_pass++;
    n_checks++; if (ex_alusrc !== 1'b1) $display("FAIL b2b_ex_alusrc2: got %b want 1", ex_alusrc); else n_pass++;
    n_checks++; if (wb_wen !== 1'b1) $display("FAIL b2b_wb_wen2: got %b want 1", wb_wen); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready2: got %b want 1", in_ready); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_checks++; if (wb_wen !== 1'b1) $display("FAIL b2b_wb_wen3: got %b want 1", wb_wen); else n_pass++;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL b2b_ex_bubble3: got %b want 0", ex_valid); else n_pass++;
    tick();
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL b2b_wb_valid4: got %b want 0", wb_valid); else n_pass++;
    n_checks++; if (wb_wen !== 1'b0) $display("FAIL b2b_wb_wen4: got %b want 0", wb_wen); else n_pass++;
  endtask

  task automatic test_mul();
    int busy_cycles;
    int ready_low;
    in_valid  = 1'b1;
    in_opcode = 6'h05;
    tick();
    busy_cycles = busy ? 1 : 0;
    ready_low   = in_ready ? 0 : 1;
    n_checks++; if (ex_aluop !== 3'd5) $display("FAIL mul_ex_aluop: got %0d want 5", ex_aluop); else n_pass++;
    in_opcode = 6'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy) busy_cycles++;
      if (!in_ready) ready_low++;
      n_checks++; if (wb_valid !== 1'b0) $display("FAIL mul_wb_bubble%0d: got %b want 0", i, wb_valid); else n_pass++;
      n_checks++; if (ex_aluop !== 3'd5) $display("FAIL mul_ex_hold%0d: got %0d want 5", i, ex_aluop); else n_pass++;
    end
    n_checks++; if (busy_cycles != 3) $display("FAIL mul_busy_cycles: got %0d want 3", busy_cycles); else n_pass++;
    n_checks++; if (ready_low != 3) $display("FAIL mul_ready_low: got %0d want 3", ready_low); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mul_ready_after: got %b want 1", in_ready); else n_pass++;
    tick();
    n_checks++; if (ex_aluop !== 3'd1) $display("FAIL mul_sub_in_ex: got %0d want 1", ex_aluop); else n_pass++;
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL mul_wb_valid: got %b want 1", wb_valid); else n_pass++;
    n_checks++; if (wb_wen !== 1'b1) $display("FAIL mul_wb_wen: got %b want 1", wb_wen); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL mul_sub_wb: got %b want 1", wb_valid); else n_pass++;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL mul_ex_drain: got %b want 0", ex_valid); else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    in_valid  = 1'b1;
    in_opcode = 6'h03;
    tick();
    n_checks++; if (ex_aluop !== 3'b011) $display("FAIL stall_xor_ex: got %0d want 3", ex_aluop); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL stall_wb_pre: got %b want 0", wb_valid); else n_pass++;
    stall_in  = 1'b1;
    in_opcode = 6'h08;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", in_ready); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (ex_aluop !== 3'b011) $display("FAIL stall_ex_hold%0d: got %0d want 3", i, ex_aluop); else n_pass++;
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL stall_ex_valid%0d: got %b want 1", i, ex_valid); else n_pass++;
      n_checks++; if (wb_valid !== 1'b0) $display("FAIL stall_wb_hold%0d: got %b want 0", i, wb_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", i, in_ready); else n_pass++;
    end
    stall_in = 1'b0;
    tick();
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL stall_xor_wb: got %b want 1", wb_valid); else n_pass++;
    n_checks++; if (wb_wen !== 1'b1) $display("FAIL stall_xor_wen: got %b want 1", wb_wen); else n_pass++;
    n_checks++; if (ex_alusrc !== 1'b1) $display("FAIL stall_addi_ex: got %b want 1", ex_alusrc); else n_pass++;
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_illegal();
    in_valid  = 1'b1;
    in_opcode = 6'h3F;
    tick();
    n_checks++; if (ex_aluop !== 3'b111) $display("FAIL ill_ex_aluop: got %0d want 7", ex_aluop); else n_pass++;
    n_checks++; if (ex_regdst !== !c_trap) $display("FAIL ill_ex_regdst: got %b want %b", ex_regdst, !c_trap); else n_pass++;
    n_checks++; if (illegal !== c_trap) $display("FAIL ill_flag: got %b want %b", illegal, c_trap); else n_pass++;
    in_opcode = 6'h00;
    tick();
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL ill_wb_valid: got %b want 1", wb_valid); else n_pass++;
    n_checks++; if (wb_wen !== !c_trap) $display("FAIL ill_wb_wen: got %b want %b", wb_wen, !c_trap); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_checks++; if (illegal !== c_trap) $display("FAIL ill_sticky: got %b want %b", illegal, c_trap); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_mul();
    in_valid  = 1'b1;
    in_opcode = 6'h05;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL rmm_busy_before: got %b want 1", busy); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmm_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (ex_valid !== 1'b0) $display("FAIL rmm_ex_valid: got %b want 0", ex_valid); else n_pass++;
    n_checks++; if (ex_aluop !== 3'd0) $display("FAIL rmm_ex_aluop: got %0d want 0", ex_aluop); else n_pass++;
    n_checks++; if (ex_regdst !== 1'b0) $display("FAIL rmm_ex_regdst: got %b want 0", ex_regdst); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL rmm_illegal: got %b want 0", illegal); else n_pass++;
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rmm_ready: got %b want 1", in_ready); else n_pass++;
    in_valid  = 1'b1;
    in_opcode = 6'h00;
    tick();
    n_checks++; if (ex_valid !== 1'b1) $display("FAIL rmm_add_ex: got %b want 1", ex_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmm_add_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL rmm_add_wb_early: got %b want 0", wb_valid); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_checks++; if (wb_wen !== 1'b1) $display("FAIL rmm_add_wb: got %b want 1", wb_wen); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 6'h00;
    stall_in  = 1'b0;
    test_reset();
    test_back_to_back();
    test_mul();
    test_stall();
    test_illegal();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 6: opcode width, minimum 4.
REQ-002 SHALL have parameter AOPW, default 3: ALU-op width, taken from opcode[AOPW-1:0], minimum 3 and less than OPW.
REQ-003 SHALL have parameter MUL_CYC, default 4: EX occupancy of MUL in cycles, range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: opcode presented.
REQ-007 SHALL have port in_opcode, input, OPW bits: instruction opcode.
REQ-008 SHALL have port in_ready, output, 1 bit: opcode accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port stall_in, input, 1 bit: downstream stall that freezes EX and WB.
REQ-010 SHALL have port ex_valid, ex_alusrc, ex_regdst, outputs, 1 bit each: EX-stage controls.
REQ-011 SHALL have port ex_aluop, output, AOPW bits: EX-stage ALU operation.
REQ-012 SHALL have port wb_valid, wb_wen, outputs, 1 bit each: WB-stage controls.
REQ-013 SHALL have port busy, output, 1 bit: MUL in progress.
REQ-014 SHALL have port illegal, output, 1 bit: sticky illegal-opcode flag (REQ-030).

Function
REQ-015 SHALL decode opcodes as follows:
- R-type (ADD, SUB, AND, XOR, COM, MUL): wen=1, alusrc=0, regdst=1.
- ADDI: wen=1, alusrc=1, regdst=0.
- aluop = opcode[AOPW-1:0] for every opcode.
REQ-016 SHALL load the decoded controls into the EX register on an accepted transfer, giving 1-cycle latency from acceptance to ex_*.
REQ-017 SHALL move EX contents into the WB register one cycle later when EX is not held, giving 2-cycle latency from acceptance to wb_*.
REQ-018 SHALL drive in_ready = !stall_in && state==RUN.
REQ-019 SHALL hold all EX and WB registers unchanged for as long as stall_in=1.
REQ-020 SHALL load ex_valid=0 (a bubble) when EX advances and no transfer is accepted.
REQ-021 SHALL implement the FSM states RUN and MUL_WAIT; the reset state SHALL be RUN.
REQ-022 SHALL, on accepting MUL with MUL_CYC>1, go to MUL_WAIT and load the counter with MUL_CYC-1.
REQ-023 SHALL, in MUL_WAIT without stall_in:
- decrement the counter;
- hold EX;
- insert WB bubbles (wb_valid=0);
- return to RUN when the counter reaches 0, after which MUL advances to WB on the next cycle.
REQ-024 SHALL freeze the counter while stall_in=1.
REQ-025 SHALL drive busy=1 exactly while state==MUL_WAIT.
REQ-026 SHALL, with MUL_CYC=1, treat MUL like any other opcode and never enter MUL_WAIT.
REQ-027 SHALL force wb_wen=0 whenever wb_valid=0.

Reset
REQ-028 SHALL, on rst_n low, asynchronously:
- clear ex_valid, ex_alusrc, ex_regdst, ex_aluop, wb_valid, wb_wen, busy, illegal and the counter;
- set state=RUN.
REQ-029 SHALL treat reset asserted mid-MUL as aborting the MUL; the first accept after release SHALL behave as from an empty pipe.

Configuration
REQ-030 SHALL, with ILLEGAL_TRAP_EN defined:
- decode an unlisted opcode as wen=0, alusrc=0, regdst=0;
- set illegal one cycle after acceptance, sticky until reset.
REQ-031 SHALL, without ILLEGAL_TRAP_EN:
- decode an unlisted opcode as R-type (wen=1, alusrc=0, regdst=1);
- tie illegal to 0.

Structure
REQ-032 SHALL place the following in shared package pipe_pkg:
- opcode constants ADD=6'h00, SUB=6'h01, AND=6'h02, XOR=6'h03, COM=6'h04, MUL=6'h05, ADDI=6'h08;
- the FSM state typedef;
- the decoded-control struct.
REQ-033 SHALL contain the combinational decode in one sub-module, ctrl_dec; the top level SHALL hold the pipeline registers, FSM and counter.

Verification
REQ-034 SHALL cover the ADD/ADDI back-to-back scenario:
- stimulus: ADD (6'h00) then ADDI (6'h08) on consecutive cycles;
- response: ex_regdst=1,0 on cycles 1 and 2; wb_wen=1,1 on cycles 2 and 3; in_ready constant 1.
REQ-035 SHALL cover the MUL scenario:
- stimulus: MUL with MUL_CYC=4, then SUB on the next cycle;
- response: busy=1 for 3 cycles; in_ready=0 for 3 cycles; WB bubbles during MUL_WAIT; SUB accepted the cycle after busy falls; SUB reaches EX one cycle later.
REQ-036 SHALL cover the stall scenario:
- stimulus: stall_in=1 for 2 cycles with XOR in EX;
- response: ex_aluop=3'b011 held; wb_* unchanged; in_ready=0; XOR reaches WB one cycle after the stall is released.
REQ-037 SHALL cover the illegal-opcode scenario:
- stimulus: opcode 6'h3F;
- response with ILLEGAL_TRAP_EN: wb_wen=0 and illegal=1, staying 1 after further legal opcodes;
- response without ILLEGAL_TRAP_EN: wb_wen=1 and illegal=0.
REQ-038 SHALL cover the reset-mid-MUL scenario:
- stimulus: rst_n low in the second MUL_WAIT cycle;
- response: all outputs 0 immediately; in_ready=1 after release; a subsequent ADD completes with 2-cycle latency.
